imm_gen_pipe: RTL and testbench
===============================

# imm_gen_pipe

Parametrised, elastic RV32I/RV64I immediate generator. Decodes every base immediate format (I, shift-I, S, B, U, J) from a 32-bit instruction, sign-extends to XLEN, and delivers the result through a valid/ready pipeline of 1 or 2 register stages. Sits between fetch/IF-ID and the ID/EX register, replacing the single-format combinational sign extender. Adds flush, backpressure, format tagging and illegal-opcode flagging.

## Interface
- XLEN, 32: datapath width; legal values 32 and 64.
- STAGES, 1: register stages, 1 or 2; equals latency in cycles.
- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  reset, asynchronous, active-low.
- flush_i  in  1  synchronous flush of all in-flight entries.
- in_valid_i  in  1  instruction valid.
- in_ready_o  out  1  block accepts instruction this cycle.
- instr_i  in  32  instruction word.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  consumer accepts result.
- imm_o  out  XLEN  extended immediate.
- fmt_o  out  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 7=invalid.
- illegal_o  out  1  opcode not in decoded set.
- acc_cnt_o  out  32  accepted results (see Configuration).
- ill_cnt_o  out  16  accepted illegal results (see Configuration).

## Operation
- Decode by instr_i[6:0]:
  - 0010011, 0000011, 1100111, 1110011 → I: sext(instr[31:20]).
  - 0010011 with funct3 001/101 → I, imm = zext(shamt): instr[24:20] for XLEN=32, instr[25:20] for XLEN=64; funct7 bits excluded.
  - 0100011 → S: sext({instr[31:25], instr[11:7]}).
  - 1100011 → B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}); byte offset, bit 0 always 0.
  - 0110111, 0010111 → U: sext({instr[31:12], 12'b0}).
  - 1101111 → J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - 0110011 → R, imm 0.
  - Any other → fmt 7, imm 0, illegal_o 1.
- Sign extension replicates the top immediate bit through bit XLEN-1.
- STAGES=1: decode is combinational into one output register. STAGES=2: stage 1 registers instr_i; stage 2 registers the decoded result.
- Each stage holds its content while the downstream stage is full and not draining. Ready chain: stage_ready = !stage_valid || next_ready; in_ready_o = stage1_ready && !flush_i.
- Transfer in: in_valid_i && in_ready_o. Transfer out: out_valid_o && out_ready_i.
- Throughput is 1 result per cycle when out_ready_i is held high.

## Timing
- Reset (rst_n_i low, asynchronous): all stage valids 0, out_valid_o 0, imm_o 0, fmt_o 0, illegal_o 0, counters 0. in_ready_o is 1 after release while flush_i is 0.
- Latency: an instruction accepted at edge N presents out_valid_o after edge N+STAGES-1 (STAGES=1: visible the cycle after acceptance; STAGES=2: one cycle later), assuming no stall.
- Stall: while out_valid_o && !out_ready_i, imm_o, fmt_o and illegal_o are stable and in_ready_o falls once all stages are full. No entry is dropped or duplicated.
- Full pipeline with out_ready_i 1 and in_valid_i 1: accept and emit in the same cycle; no bubble.
- flush_i high at an edge: all valids clear at that edge, and in_ready_o is 0 during that cycle. Flush wins over a simultaneous accept or emit. Data registers may retain stale values; only valids are architectural.
- Reset asserted mid-stall: outputs clear immediately, and no result is emitted after release.
- out_valid_o and outputs come from registers only. in_ready_o is combinational from out_ready_i and flush_i.

## Configuration
- IMM_GEN_STATS_EN defined:
  - acc_cnt_o increments on every output transfer.
  - ill_cnt_o increments on output transfers with illegal_o 1.
  - Both counters saturate at all-ones, clear on reset, and do not change on flush.
- IMM_GEN_STATS_EN undefined: no counter flops; acc_cnt_o and ill_cnt_o are tied to 0.

## Test plan
- XLEN=32: 0xFFF00093 (addi -1) → imm 0xFFFFFFFF, fmt 1. 0xFE112E23 (sw x1,-4(x2)) → imm 0xFFFFFFFC, fmt 2.
- Branch: 0xFE000CE3 (beq -8) → imm 0xFFFFFFF8, fmt 3. Shift: 0x4030D093 (srai 3) → imm 0x00000003, fmt 1, funct7 not leaked.
- XLEN=64: 0x800000B7 (lui 0x80000) → imm 0xFFFFFFFF80000000, fmt 4. 0xFFFFFFFF → fmt 7, illegal 1, imm 0.
- Backpressure, STAGES=2: stream 8 instructions with out_ready_i toggling 1,0,0,1.
  - All 8 emitted in order, none lost or duplicated, outputs stable during stalls.
  - in_ready_o is 0 while both stages are full and stalled.
- Flush: flush_i pulsed with 2 entries in flight and in_valid_i 1 → out_valid_o 0 next cycle, flushed entries never appear, the next accepted instruction is emitted normally.
- IMM_GEN_STATS_EN: 5 legal + 2 illegal outputs → acc_cnt_o 7, ill_cnt_o 2. Asynchronous reset mid-stream → all outputs 0 immediately.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// RV32I/RV64I immediate generator with a 1- or 2-stage valid/ready pipeline.
// Define IMM_GEN_STATS_EN to enable the saturating accepted/illegal result counters.
module imm_gen_pipe #(
    parameter int XLEN   = 32,
    parameter int STAGES = 1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [31:0]      instr_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [XLEN-1:0]  imm_o,
    output logic [2:0]       fmt_o,
    output logic             illegal_o,
    output logic [31:0]      acc_cnt_o,
    output logic [15:0]      ill_cnt_o
);

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            ill;
    } dec_t;

    // Immediate is built as a signed 32-bit value, then sign-extended to XLEN.
    function automatic dec_t decode(input logic [31:0] ins);
        dec_t r;
        logic signed [31:0] s;
        r     = '0;
        r.fmt = 3'd7;
        r.ill = 1'b1;
        s     = '0;
        case (ins[6:0])
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
                r.fmt = 3'd1;
                r.ill = 1'b0;
                if (ins[6:0] == 7'b0010011 && ins[13:12] == 2'b01) begin
                    if (XLEN == 64) s = {26'b0, ins[25:20]};
                    else            s = {27'b0, ins[24:20]};
                end else begin
                    s = {{20{ins[31]}}, ins[31:20]};
                end
            end
            7'b0100011: begin
                r.fmt = 3'd2;
                r.ill = 1'b0;
                s     = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            end
            7'b1100011: begin
                r.fmt = 3'd3;
                r.ill = 1'b0;
                s     = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                r.fmt = 3'd4;
                r.ill = 1'b0;
                s     = {ins[31:12], 12'b0};
            end
            7'b1101111: begin
                r.fmt = 3'd5;
                r.ill = 1'b0;
                s     = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            end
            7'b0110011: begin
                r.fmt = 3'd0;
                r.ill = 1'b0;
            end
            default: ;
        endcase
        r.imm = XLEN'(s);
        return r;
    endfunction

    logic        out_vld_q;
    dec_t        out_q;
    dec_t        out_d;
    logic        out_rdy;
    logic        dec_vld;
    logic [31:0] dec_src;

    assign out_rdy = !out_vld_q || out_ready_i;
    assign out_d   = decode(dec_src);

    generate
        if (STAGES == 2) begin : g_s2
            logic        s1_vld_q;
            logic [31:0] s1_instr_q;

            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    s1_vld_q   <= 1'b0;
                    s1_instr_q <= '0;
                end else if (flush_i) begin
                    s1_vld_q <= 1'b0;
                end else if (!s1_vld_q || out_rdy) begin
                    s1_vld_q <= in_valid_i;
                    if (in_valid_i) s1_instr_q <= instr_i;
                end
            end

            assign in_ready_o = (!s1_vld_q || out_rdy) && !flush_i;
            assign dec_vld    = s1_vld_q;
            assign dec_src    = s1_instr_q;
        end else begin : g_s1
            assign in_ready_o = out_rdy && !flush_i;
            assign dec_vld    = in_valid_i;
            assign dec_src    = instr_i;
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            out_vld_q <= 1'b0;
            out_q     <= '0;
        end else if (flush_i) begin
            out_vld_q <= 1'b0;
        end else if (out_rdy) begin
            out_vld_q <= dec_vld;
            if (dec_vld) out_q <= out_d;
        end
    end

    assign out_valid_o = out_vld_q;
    assign imm_o       = out_q.imm;
    assign fmt_o       = out_q.fmt;
    assign illegal_o   = out_q.ill;

`ifdef IMM_GEN_STATS_EN
    logic [31:0] acc_cnt_q;
    logic [15:0] ill_cnt_q;
    logic        xfer;

    // Flush suppresses the emit, so it never counts.
    assign xfer = out_vld_q && out_ready_i && !flush_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            acc_cnt_q <= '0;
            ill_cnt_q <= '0;
        end else if (xfer) begin
            if (acc_cnt_q != '1)              acc_cnt_q <= acc_cnt_q + 32'd1;
            if (out_q.ill && ill_cnt_q != '1) ill_cnt_q <= ill_cnt_q + 16'd1;
        end
    end

    assign acc_cnt_o = acc_cnt_q;
    assign ill_cnt_o = ill_cnt_q;
`else
    assign acc_cnt_o = '0;
    assign ill_cnt_o = '0;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: dut_a is XLEN=32/STAGES=1, dut_b is XLEN=64/STAGES=2.
// Expected results are queued at acceptance and popped by per-DUT output monitors.
module tb_imm_gen_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        flush_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a, ill_a;
    logic [31:0] instr_a, imm_a, acc_a;
    logic [2:0]  fmt_a;
    logic [15:0] illc_a;

    logic        flush_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b, ill_b;
    logic [31:0] instr_b, acc_b;
    logic [63:0] imm_b;
    logic [2:0]  fmt_b;
    logic [15:0] illc_b;

    imm_gen_pipe #(.XLEN(32), .STAGES(1)) dut_a (
        .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush_a), .in_valid_i(in_valid_a),
        .in_ready_o(in_ready_a), .instr_i(instr_a), .out_valid_o(out_valid_a),
        .out_ready_i(out_ready_a), .imm_o(imm_a), .fmt_o(fmt_a), .illegal_o(ill_a),
        .acc_cnt_o(acc_a), .ill_cnt_o(illc_a));

    imm_gen_pipe #(.XLEN(64), .STAGES(2)) dut_b (
        .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush_b), .in_valid_i(in_valid_b),
        .in_ready_o(in_ready_b), .instr_i(instr_b), .out_valid_o(out_valid_b),
        .out_ready_i(out_ready_b), .imm_o(imm_b), .fmt_o(fmt_b), .illegal_o(ill_b),
        .acc_cnt_o(acc_b), .ill_cnt_o(illc_b));

    int tests = 0;
    int fails = 0;
    int emit_a = 0;
    int full_stalls = 0;

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } exp_t;
    exp_t qa[$];
    exp_t qb[$];

    // Backpressure pattern 1,0,0,1 for dut_b when bp_mode is set
    logic bp_mode, bp_pat, rdy_b_force;
    int   cyc = 0;
    always @(posedge clk) begin
        #1;
        cyc++;
        bp_pat = (cyc % 4 == 0) || (cyc % 4 == 3);
    end
    assign out_ready_b = bp_mode ? bp_pat : rdy_b_force;

    function automatic exp_t mk(input logic [63:0] imm, input logic [2:0] fmt, input logic ill);
        exp_t e;
        e.imm = imm; e.fmt = fmt; e.ill = ill;
        return e;
    endfunction

    // Reference decoder: sign extension done through signed 64-bit casts
    function automatic exp_t ref_dec(input logic [31:0] i, input int xlen);
        exp_t e;
        logic signed [63:0] v;
        v = '0; e.fmt = 3'd7; e.ill = 1'b1;
        case (i[6:0])
            7'h13, 7'h03, 7'h67, 7'h73: begin
                e.fmt = 3'd1; e.ill = 1'b0;
                if (i[6:0] == 7'h13 && (i[14:12] == 3'b001 || i[14:12] == 3'b101))
                    v = (xlen == 64) ? 64'(i[25:20]) : 64'(i[24:20]);
                else
                    v = 64'($signed(i[31:20]));
            end
            7'h23: begin e.fmt = 3'd2; e.ill = 1'b0; v = 64'($signed({i[31:25], i[11:7]})); end
            7'h63: begin e.fmt = 3'd3; e.ill = 1'b0; v = 64'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0})); end
            7'h37, 7'h17: begin e.fmt = 3'd4; e.ill = 1'b0; v = 64'($signed({i[31:12], 12'h000})); end
            7'h6F: begin e.fmt = 3'd5; e.ill = 1'b0; v = 64'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0})); end
            7'h33: begin e.fmt = 3'd0; e.ill = 1'b0; end
            default: ;
        endcase
        e.imm = (xlen == 32) ? {32'h0, v[31:0]} : v;
        return e;
    endfunction

    // dut_a output monitor
    always @(negedge clk) begin
        if (rst_n && out_valid_a && out_ready_a && !flush_a) begin
            exp_t e;
            emit_a++;
            tests++;
            if (qa.size() == 0) begin
                fails++;
                $display("FAIL a_unexpected_out: got imm=%h fmt=%0d ill=%b, required no output", imm_a, fmt_a, ill_a);
            end else begin
                e = qa.pop_front();
                if ({32'h0, imm_a} !== e.imm || fmt_a !== e.fmt || ill_a !== e.ill) begin
                    fails++;
                    $display("FAIL a_out: got imm=%h fmt=%0d ill=%b, required imm=%h fmt=%0d ill=%b",
                             imm_a, fmt_a, ill_a, e.imm[31:0], e.fmt, e.ill);
                end
            end
        end
    end

    // dut_b output monitor with stall-hold and ready checks
    logic [63:0] p_imm;
    logic [2:0]  p_fmt;
    logic        p_ill;
    logic        p_stall = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (p_stall && out_valid_b) begin
                tests++;
                if (imm_b !== p_imm || fmt_b !== p_fmt || ill_b !== p_ill) begin
                    fails++;
                    $display("FAIL b_stall_hold: got imm=%h fmt=%0d, required imm=%h fmt=%0d", imm_b, fmt_b, p_imm, p_fmt);
                end
            end
            if (!in_ready_b && !flush_b) begin
                tests++;
                if (!(out_valid_b && !out_ready_b)) begin
                    fails++;
                    $display("FAIL b_in_ready_low: got in_ready=0 with out_valid=%b out_ready=%b, required a stalled output", out_valid_b, out_ready_b);
                end
            end
            if (out_valid_b && !out_ready_b && !in_ready_b) full_stalls++;
            if (out_valid_b && out_ready_b && !flush_b) begin
                exp_t e;
                tests++;
                if (qb.size() == 0) begin
                    fails++;
                    $display("FAIL b_unexpected_out: got imm=%h fmt=%0d, required no output", imm_b, fmt_b);
                end else begin
                    e = qb.pop_front();
                    if (imm_b !== e.imm || fmt_b !== e.fmt || ill_b !== e.ill) begin
                        fails++;
                        $display("FAIL b_out: got imm=%h fmt=%0d ill=%b, required imm=%h fmt=%0d ill=%b",
                                 imm_b, fmt_b, ill_b, e.imm, e.fmt, e.ill);
                    end
                end
            end
        end
        p_stall <= rst_n && out_valid_b && !out_ready_b && !flush_b;
        p_imm   <= imm_b;
        p_fmt   <= fmt_b;
        p_ill   <= ill_b;
    end

    task automatic send_a(input logic [31:0] ins, input exp_t e);
        int n = 0;
        in_valid_a = 1'b1; instr_a = ins;
        do begin @(negedge clk); n++; end while (!in_ready_a && n < 200);
        if (!in_ready_a) begin
            tests++; fails++;
            $display("FAIL a_send_timeout: got in_ready=0 for %0d cycles, required 1", n);
        end else qa.push_back(e);
        @(posedge clk); #1;
        in_valid_a = 1'b0;
    endtask

    task automatic send_b(input logic [31:0] ins, input exp_t e);
        int n = 0;
        in_valid_b = 1'b1; instr_b = ins;
        do begin @(negedge clk); n++; end while (!in_ready_b && n < 200);
        if (!in_ready_b) begin
            tests++; fails++;
            $display("FAIL b_send_timeout: got in_ready=0 for %0d cycles, required 1", n);
        end else qb.push_back(e);
        @(posedge clk); #1;
        in_valid_b = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 200) begin @(negedge clk); n++; end
        if (qa.size() != 0 || qb.size() != 0) begin
            tests++; fails++;
            $display("FAIL drain_timeout: got %0d/%0d pending, required 0/0", qa.size(), qb.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        tests++;
        if (out_valid_a !== 1'b0 || imm_a !== 32'h0 || fmt_a !== 3'd0 || ill_a !== 1'b0 || acc_a !== 32'h0 || illc_a !== 16'h0) begin
            fails++;
            $display("FAIL reset_a: got v=%b imm=%h fmt=%0d ill=%b acc=%0d illc=%0d, required all 0", out_valid_a, imm_a, fmt_a, ill_a, acc_a, illc_a);
        end
        tests++;
        if (out_valid_b !== 1'b0 || imm_b !== 64'h0 || fmt_b !== 3'd0 || ill_b !== 1'b0 || acc_b !== 32'h0 || illc_b !== 16'h0) begin
            fails++;
            $display("FAIL reset_b: got v=%b imm=%h fmt=%0d ill=%b, required all 0", out_valid_b, imm_b, fmt_b, ill_b);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (in_ready_a !== 1'b1 || in_ready_b !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready: got a=%b b=%b, required 1 1", in_ready_a, in_ready_b);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_decode32();
        send_a(32'hFFF00093, mk(64'hFFFFFFFF, 3'd1, 1'b0));
        send_a(32'hFE112E23, mk(64'hFFFFFFFC, 3'd2, 1'b0));
        send_a(32'hFE000CE3, mk(64'hFFFFFFF8, 3'd3, 1'b0));
        send_a(32'h4030D093, mk(64'h00000003, 3'd1, 1'b0));
        send_a(32'h4230D093, mk(64'h00000003, 3'd1, 1'b0));
        send_a(32'hFFDFF06F, mk(64'hFFFFFFFC, 3'd5, 1'b0));
        send_a(32'h12345017, mk(64'h12345000, 3'd4, 1'b0));
        send_a(32'h002081B3, mk(64'h0, 3'd0, 1'b0));
        send_a(32'hFFFFFFFF, mk(64'h0, 3'd7, 1'b1));
        wait_drain();
    endtask

    task automatic test_decode64();
        rdy_b_force = 1'b1;
        send_b(32'h800000B7, mk(64'hFFFFFFFF80000000, 3'd4, 1'b0));
        send_b(32'hFFFFFFFF, mk(64'h0, 3'd7, 1'b1));
        send_b(32'h4230D093, mk(64'h23, 3'd1, 1'b0));
        send_b(32'hFE000CE3, mk(64'hFFFFFFFFFFFFFFF8, 3'd3, 1'b0));
        wait_drain();
    endtask

    task automatic test_latency();
        rdy_b_force = 1'b1;
        send_b(32'hFFF00093, mk(64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0));
        @(negedge clk);
        tests++;
        if (out_valid_b !== 1'b0) begin
            fails++; $display("FAIL b_latency_early: got out_valid=%b, required 0", out_valid_b);
        end
        @(negedge clk);
        tests++;
        if (out_valid_b !== 1'b1) begin
            fails++; $display("FAIL b_latency: got out_valid=%b, required 1", out_valid_b);
        end
        wait_drain();
    endtask

    task automatic test_back_to_back();
        int start;
        logic [31:0] ins;
        out_ready_a = 1'b1;
        start = emit_a;
        for (int k = 0; k < 6; k++) begin
            ins = 32'h00100093 + (32'(k) << 20);
            in_valid_a = 1'b1; instr_a = ins;
            @(negedge clk);
            tests++;
            if (in_ready_a !== 1'b1) begin
                fails++; $display("FAIL a_b2b_ready: got %b, required 1 at beat %0d", in_ready_a, k);
            end
            qa.push_back(ref_dec(ins, 32));
            @(posedge clk); #1;
        end
        in_valid_a = 1'b0;
        @(negedge clk); #1;
        tests++;
        if (emit_a - start !== 6) begin
            fails++; $display("FAIL a_b2b_count: got %0d emitted, required 6", emit_a - start);
        end
        wait_drain();
    endtask

    task automatic test_backpressure();
        logic [31:0] prog [8];
        prog = '{32'hFFF00093, 32'hFE112E23, 32'hFE000CE3, 32'h4230D093,
                 32'h800000B7, 32'hFFDFF06F, 32'h0000007F, 32'h002081B3};
        full_stalls = 0;
        bp_mode = 1'b1;
        for (int k = 0; k < 8; k++) send_b(prog[k], ref_dec(prog[k], 64));
        wait_drain();
        bp_mode = 1'b0;
        tests++;
        if (full_stalls == 0) begin
            fails++; $display("FAIL b_full_stall_seen: got %0d full-stall cycles, required >0", full_stalls);
        end
    endtask

    task automatic test_flush();
        rdy_b_force = 1'b0;
        send_b(32'hFFF00093, mk(64'h0, 3'd0, 1'b0));
        send_b(32'hFE112E23, mk(64'h0, 3'd0, 1'b0));
        in_valid_b = 1'b1; instr_b = 32'h12345017; flush_b = 1'b1;
        @(negedge clk);
        tests++;
        if (in_ready_b !== 1'b0) begin
            fails++; $display("FAIL b_flush_ready: got in_ready=%b, required 0", in_ready_b);
        end
        @(posedge clk); #1;
        flush_b = 1'b0; in_valid_b = 1'b0;
        qb.delete();
        @(negedge clk);
        tests++;
        if (out_valid_b !== 1'b0) begin
            fails++; $display("FAIL b_flush_valid: got out_valid=%b, required 0", out_valid_b);
        end
        @(posedge clk); #1;
        rdy_b_force = 1'b1;
        send_b(32'h12345017, mk(64'h12345000, 3'd4, 1'b0));
        wait_drain();
    endtask

    task automatic test_stats();
        logic [31:0] prog [7];
        prog = '{32'hFFF00093, 32'hFFFFFFFF, 32'hFE112E23, 32'hFE000CE3,
                 32'h0000000B, 32'h12345017, 32'h002081B3};
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready_a = 1'b1;
        for (int k = 0; k < 7; k++) send_a(prog[k], ref_dec(prog[k], 32));
        wait_drain();
        @(negedge clk);
        tests++;
`ifdef IMM_GEN_STATS_EN
        if (acc_a !== 32'd7 || illc_a !== 16'd2) begin
            fails++; $display("FAIL stats: got acc=%0d ill=%0d, required 7 2", acc_a, illc_a);
        end
`else
        if (acc_a !== 32'd0 || illc_a !== 16'd0) begin
            fails++; $display("FAIL stats_off: got acc=%0d ill=%0d, required 0 0", acc_a, illc_a);
        end
`endif
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        rdy_b_force = 1'b0;
        send_b(32'hFFF00093, mk(64'h0, 3'd0, 1'b0));
        send_b(32'h800000B7, mk(64'h0, 3'd0, 1'b0));
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (out_valid_b !== 1'b0 || imm_b !== 64'h0 || fmt_b !== 3'd0 || ill_b !== 1'b0 || acc_a !== 32'h0) begin
            fails++; $display("FAIL b_reset_mid: got v=%b imm=%h fmt=%0d acc_a=%0d, required all 0", out_valid_b, imm_b, fmt_b, acc_a);
        end
        qb.delete();
        rdy_b_force = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            tests++;
            if (out_valid_b !== 1'b0) begin
                fails++; $display("FAIL b_after_reset: got out_valid=%b, required 0 at cycle %0d", out_valid_b, k);
            end
        end
    endtask

    initial begin
        #200000;
        fails++;
        $display("FAIL watchdog: got no completion, required finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        flush_a = 1'b0; in_valid_a = 1'b0; instr_a = '0; out_ready_a = 1'b1;
        flush_b = 1'b0; in_valid_b = 1'b0; instr_b = '0;
        bp_mode = 1'b0; rdy_b_force = 1'b1;
        test_reset();
        test_decode32();
        test_decode64();
        test_latency();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_stats();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
